// File: rtl/dbus_master_arbiter.sv
// Round-robin arbiter sharing one downstream data bus between NUM_MASTERS requesters.
// One transaction per grant, with a per-transaction timeout that completes with an error.
module dbus_master_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_MASTERS-1:0]         m_req,
  input  logic [NUM_MASTERS-1:0]         m_we,
  input  logic [4*NUM_MASTERS-1:0]       m_be,
  input  logic [32*NUM_MASTERS-1:0]      m_addr,
  input  logic [32*NUM_MASTERS-1:0]      m_wdata,
  output logic [NUM_MASTERS-1:0]         m_ack,
  output logic [NUM_MASTERS-1:0]         m_err,
  output logic [31:0]                    m_rdata,
  output logic                           s_req,
  output logic                           s_we,
  output logic [3:0]                     s_be,
  output logic [31:0]                    s_addr,
  output logic [31:0]                    s_wdata,
  input  logic [31:0]                    s_rdata,
  input  logic                           s_ack,
  output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
  output logic                           busy
);

  localparam int GW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TERM_CNT  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [GW-1:0] LAST_INIT = GW'(NUM_MASTERS - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t         state_r, state_s;
  logic [GW-1:0]  grant_r, last_grant_r, pick_s;
  logic [CW-1:0]  cnt_r;
  logic           term_s, done_s;

  logic [3:0]     be_a    [NUM_MASTERS];
  logic [31:0]    addr_a  [NUM_MASTERS];
  logic [31:0]    wdata_a [NUM_MASTERS];

  // Index arithmetic must wrap modulo NUM_MASTERS, which need not be a power of two.
  function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    return GW'(sum % NUM_MASTERS);
  endfunction

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign be_a[g]    = m_be[4*g+3 : 4*g];
    assign addr_a[g]  = m_addr[32*g+31 : 32*g];
    assign wdata_a[g] = m_wdata[32*g+31 : 32*g];
  end

  assign term_s   = (cnt_r == TERM_CNT);
  assign done_s   = (state_r == BUSY) && (s_ack || term_s);
  assign busy     = (state_r == BUSY);
  assign grant_id = grant_r;

  // Round-robin pick: scanning offsets from far to near lets the nearest requester win.
  always_comb begin
    pick_s = last_grant_r;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      pick_s = m_req[wrap_idx(last_grant_r, i)] ? wrap_idx(last_grant_r, i) : pick_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = (|m_req) ? BUSY : IDLE;
      BUSY:    state_s = done_s ? IDLE : BUSY;
      default: state_s = IDLE;
    endcase
  end

  // Downstream mux and completion signalling; s_ack takes precedence over the timeout
  always_comb begin
    m_ack   = {NUM_MASTERS{1'b0}};
    m_err   = {NUM_MASTERS{1'b0}};
    m_rdata = 32'h0000_0000;
    s_req   = 1'b0;
    s_we    = 1'b0;
    s_be    = 4'h0;
    s_addr  = 32'h0000_0000;
    s_wdata = 32'h0000_0000;
    if (state_r == BUSY) begin
      s_req   = 1'b1;
      s_we    = m_we[grant_r];
      s_be    = be_a[grant_r];
      s_addr  = addr_a[grant_r];
      s_wdata = wdata_a[grant_r];
      if (s_ack) begin
        m_ack[grant_r] = 1'b1;
        m_rdata        = s_rdata;
      end else if (term_s) begin
        m_ack[grant_r] = 1'b1;
        m_err[grant_r] = 1'b1;
      end else begin
        m_rdata = 32'h0000_0000;
      end
    end else begin
      s_req = 1'b0;
    end
  end

  // State, grant and timeout counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      grant_r      <= {GW{1'b0}};
      last_grant_r <= LAST_INIT;
      cnt_r        <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          cnt_r <= {CW{1'b0}};
          if (|m_req) begin
            grant_r <= pick_s;
          end else begin
            grant_r <= grant_r;
          end
        end
        BUSY: begin
          if (done_s) begin
            last_grant_r <= grant_r;
            cnt_r        <= {CW{1'b0}};
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: cnt_r <= {CW{1'b0}};
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_master_arbiter.sv
// Self-checking bench for dbus_master_arbiter: transaction-level reference model,
// per-cycle comparison, directed scenarios with literal expectations, then random traffic.
module tb_dbus_master_arbiter;

  localparam int N  = 3;
  localparam int T  = 8;
  localparam int GW = $clog2(N);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    m_req, m_we;
  logic [4*N-1:0]  m_be;
  logic [32*N-1:0] m_addr, m_wdata;
  logic [N-1:0]    m_ack, m_err;
  logic [31:0]     m_rdata;
  logic            s_req, s_we;
  logic [3:0]      s_be;
  logic [31:0]     s_addr, s_wdata, s_rdata;
  logic            s_ack;
  logic [GW-1:0]   grant_id;
  logic            busy;

  dbus_master_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_be(m_be),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_ack(m_ack), .m_err(m_err),
    .m_rdata(m_rdata), .s_req(s_req), .s_we(s_we), .s_be(s_be),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ack(s_ack),
    .grant_id(grant_id), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: is a transaction open, who owns it, who went last, BUSY cycles already spent
  bit mvalid = 1'b0;
  bit mb;
  int mg, ml, mage;
  logic [N-1:0] e_ack, e_err;
  logic [31:0]  e_rdata;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic settle_check();
    logic [31:0] ew, ea, ed;
    logic [3:0]  eb;
    #1;
    e_ack = '0; e_err = '0; e_rdata = 32'h0;
    ew = 32'h0; ea = 32'h0; ed = 32'h0; eb = 4'h0;
    if (mb) begin
      ew = {31'h0, m_we[mg]};
      eb = m_be[mg*4 +: 4];
      ea = m_addr[mg*32 +: 32];
      ed = m_wdata[mg*32 +: 32];
      if (s_ack) begin
        e_ack[mg] = 1'b1; e_rdata = s_rdata;
      end else if (mage == T-1) begin
        e_ack[mg] = 1'b1; e_err[mg] = 1'b1;
      end
    end
    if (mvalid) begin
      chk("busy", {31'h0, busy}, {31'h0, mb});
      chk("s_req", {31'h0, s_req}, {31'h0, mb});
      chk("s_we", {31'h0, s_we}, ew);
      chk("s_be", {28'h0, s_be}, {28'h0, eb});
      chk("s_addr", s_addr, ea);
      chk("s_wdata", s_wdata, ed);
      chk("m_ack", 32'(m_ack), 32'(e_ack));
      chk("m_err", 32'(m_err), 32'(e_err));
      chk("m_rdata", m_rdata, e_rdata);
      chk("grant_id", 32'(grant_id), 32'(mg));
    end
  endtask

  task automatic advance();
    bit found;
    @(posedge clk);
    if (rst) begin
      mvalid = 1'b1; mb = 1'b0; mg = 0; ml = N-1; mage = 0;
    end else if (mvalid) begin
      if (mb) begin
        if (s_ack || mage == T-1) begin
          mb = 1'b0; ml = mg; mage = 0;
        end else begin
          mage++;
        end
      end else begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          if (!found && m_req[(ml + k) % N]) begin
            found = 1'b1; mb = 1'b1; mg = (ml + k) % N; mage = 0;
          end
        end
      end
    end
    #1;
  endtask

  task automatic cycle();
    settle_check();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1; m_req = '0; s_ack = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  int order[$];
  int n;
  bit done;
  int ackp;

  initial begin
    rst = 1'b1; m_req = '0; m_we = '0; m_be = '0; m_addr = '0; m_wdata = '0;
    s_ack = 1'b0; s_rdata = 32'h0;

    // Reset state
    do_reset();
    settle_check();
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_s_req", {31'h0, s_req}, 32'h0);
    chk("rst_grant", 32'(grant_id), 32'h0);
    chk("rst_s_addr", s_addr, 32'h0);
    advance();

    // Single read by master 1, slave acks 3 cycles after s_req
    m_req = 3'b010; m_we = 3'b000; m_be[7:4] = 4'hF; m_addr[63:32] = 32'h0001_0004;
    cycle();
    for (int c = 1; c <= 4; c++) begin
      s_ack = (c == 4);
      s_rdata = (c == 4) ? 32'hCAFE_F00D : $urandom;
      settle_check();
      if (c == 1) chk("rd_s_req", {31'h0, s_req}, 32'h1);
      if (c == 1) chk("rd_s_addr", s_addr, 32'h0001_0004);
      if (c < 4) chk("rd_no_ack", 32'(m_ack), 32'h0);
      if (c == 4) begin
        chk("rd_ack", 32'(m_ack), 32'h2);
        chk("rd_data", m_rdata, 32'hCAFE_F00D);
        chk("rd_err", 32'(m_err), 32'h0);
        chk("rd_grant", 32'(grant_id), 32'h1);
      end
      advance();
    end
    m_req = '0; s_ack = 1'b0;
    settle_check();
    chk("rd_idle_after", {31'h0, s_req}, 32'h0);
    advance();

    // Contention from reset with immediate acks: grants alternate 0,1,0,1
    do_reset();
    m_req = 3'b011; s_ack = 1'b1;
    order.delete();
    for (int c = 0; c < 30 && order.size() < 4; c++) begin
      s_rdata = $urandom;
      settle_check();
      if (m_ack != '0) order.push_back(onehot_idx(m_ack));
      advance();
    end
    chk("cont_count", 32'(order.size()), 32'd4);
    for (int k = 0; k < order.size(); k++) chk("cont_order", 32'(order[k]), 32'(k % 2));
    m_req = '0; s_ack = 1'b0;
    cycle();

    // Timeout: master 0 write, slave silent
    m_req = 3'b001; m_we = 3'b001; m_be[3:0] = 4'hF;
    m_addr[31:0] = 32'h0000_0100; m_wdata[31:0] = 32'h1234_5678;
    cycle();
    n = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      settle_check();
      n++;
      if (m_ack != '0) begin
        done = 1'b1;
        chk("to_cycles", 32'(n), 32'd8);
        chk("to_ack", 32'(m_ack), 32'h1);
        chk("to_err", 32'(m_err), 32'h1);
        chk("to_rdata", m_rdata, 32'h0);
      end
      advance();
    end
    if (!done) chk("to_bound", 32'h0, 32'h1);
    m_req = '0;
    settle_check();
    chk("to_idle", {31'h0, busy}, 32'h0);
    advance();

    // Ack on terminal count: s_ack wins over the timeout
    m_req = 3'b100; m_we = 3'b000;
    cycle();
    for (int c = 1; c <= 8; c++) begin
      s_ack = (c == 8);
      s_rdata = (c == 8) ? 32'h0000_00AA : $urandom;
      settle_check();
      if (c == 8) begin
        chk("tc_ack", 32'(m_ack), 32'h4);
        chk("tc_err", 32'(m_err), 32'h0);
        chk("tc_rdata", m_rdata, 32'h0000_00AA);
      end
      advance();
    end
    m_req = '0; s_ack = 1'b0;
    cycle();

    // Reset mid-transaction while master 1 is granted
    m_req = 3'b010;
    cycle();
    settle_check();
    chk("mid_grant", 32'(grant_id), 32'h1);
    advance();
    rst = 1'b1;
    cycle();
    rst = 1'b0; m_req = 3'b011;
    settle_check();
    chk("mid_s_req", {31'h0, s_req}, 32'h0);
    chk("mid_busy", {31'h0, busy}, 32'h0);
    chk("mid_no_ack", 32'(m_ack), 32'h0);
    advance();
    settle_check();
    chk("mid_restart_grant", 32'(grant_id), 32'h0);
    advance();
    s_ack = 1'b1;
    cycle();
    m_req = '0;
    cycle();
    s_ack = 1'b0;

    // Three masters all requesting: order 0,1,2 repeated; late acks in IDLE ignored
    do_reset();
    m_req = 3'b111; s_ack = 1'b1;
    order.delete();
    for (int c = 0; c < 40 && order.size() < 9; c++) begin
      s_rdata = $urandom;
      settle_check();
      if (m_ack != '0) order.push_back(onehot_idx(m_ack));
      if (!busy) chk("late_ack_ignored", 32'(m_ack), 32'h0);
      advance();
    end
    chk("rr3_count", 32'(order.size()), 32'd9);
    for (int k = 0; k < order.size(); k++) chk("rr3_order", 32'(order[k]), 32'(k % 3));
    m_req = '0; s_ack = 1'b0;
    cycle();

    // Random traffic against the model
    ackp = 60;
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) ackp = (c % 1500 == 0) ? 60 : ((c % 1500 == 500) ? 15 : 4);
      s_ack = ($urandom_range(99) < ackp);
      s_rdata = $urandom;
      rst = ($urandom_range(299) == 0);
      settle_check();
      advance();
      for (int i = 0; i < N; i++) begin
        if (e_ack[i]) m_req[i] = 1'b0;
        if (mb && mg == i && m_req[i] && $urandom_range(199) == 0) m_req[i] = 1'b0;
        if (!m_req[i] && !e_ack[i] && $urandom_range(3) == 0) begin
          m_req[i] = 1'b1;
          m_we[i] = $urandom_range(1);
          m_be[i*4 +: 4] = 4'($urandom);
          m_addr[i*32 +: 32] = $urandom;
          m_wdata[i*32 +: 32] = $urandom;
        end
      end
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
